// File: rtl/lsu_pkg.sv
// Shared access-size encodings and controller state type for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Execute-stage request/response handshake plus the data-memory port of the LSU.
interface lsu_mem_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] daddr_o;
  logic [31:0] dwdata_o;
  logic [31:0] drdata_i;
  logic [1:0]  dsize_o;
  logic        drd_o;
  logic        dwr_o;
  logic [3:0]  dbe_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
           req_unsigned_i, drdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, daddr_o,
           dwdata_o, dsize_o, drd_o, dwr_o, dbe_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
           req_unsigned_i, drdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, daddr_o,
           dwdata_o, dsize_o, drd_o, dwr_o, dbe_o
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: enables, store placement, RMW merge, load extraction, alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  input  logic        uns,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        misaligned
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be         = '0;
    lane_data  = wdata;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << off;
        lane_data = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be         = 4'b0011 << off;
        lane_data  = {2{wdata[15:0]}};
        misaligned = off[0];
      end
      SIZE_WORD: begin
        be         = 4'hF;
        misaligned = (off != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase

    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end

    byte_v = old_word[{off, 3'b000} +: 8];
    half_v = off[1] ? old_word[31:16] : old_word[15:0];
    case (size)
      SIZE_BYTE: load_data = uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SIZE_HALF: load_data = uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default:   load_data = old_word;
    endcase
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one request at a time, word-indexed memory, RMW for sub-word stores.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned RD_LAT = 0,
  parameter bit          RMW_EN = 1'b1
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  lsu_mem_ctrl_if.slave  bus
);
  localparam logic [7:0] RD_LAST = 8'(RD_LAT);

  lsu_state_t  state, state_n;
  logic [7:0]  cnt;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q, off_q, dsize_q;
  logic [31:0] wdata_q, daddr_q, dwdata_q, rdata_q;
  logic [3:0]  dbe_q;

  logic        idle, accept, rmw_sub, rd_last;
  logic [1:0]  a_size, a_off;
  logic [31:0] a_wdata;
  logic [3:0]  be;
  logic [31:0] lane_data, merged, load_data;
  logic        misaligned;

  assign idle    = (state == IDLE);
  assign accept  = idle && bus.req_valid_i;
  assign rmw_sub = RMW_EN && bus.req_we_i && (bus.req_size_i != SIZE_WORD);
  assign rd_last = (cnt == RD_LAST);

  // In IDLE the lane logic looks at the incoming request; afterwards at the captured one.
  assign a_size  = idle ? bus.req_size_i       : size_q;
  assign a_off   = idle ? bus.req_addr_i[1:0]  : off_q;
  assign a_wdata = idle ? bus.req_wdata_i      : wdata_q;

  lsu_align u_align (
    .size       (a_size),
    .off        (a_off),
    .wdata      (a_wdata),
    .old_word   (bus.drdata_i),
    .uns        (uns_q),
    .be         (be),
    .lane_data  (lane_data),
    .merged     (merged),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) begin
        if (misaligned)                    state_n = RESP;
        else if (!bus.req_we_i || rmw_sub) state_n = RD;
        else                               state_n = WR;
      end
      RD:      if (rd_last) state_n = we_q ? WR : RESP;
      WR:      state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    bus.req_ready_o = idle;
    bus.rsp_valid_o = (state == RESP);
    bus.rsp_rdata_o = (state == RESP) ? rdata_q : '0;
    bus.rsp_err_o   = (state == RESP) && err_q;
    bus.drd_o       = (state == RD);
    bus.dwr_o       = (state == WR);
    bus.daddr_o     = daddr_q;
    bus.dwdata_o    = dwdata_q;
    bus.dsize_o     = dsize_q;
    bus.dbe_o       = dbe_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SIZE_WORD;
      off_q    <= '0;
      wdata_q  <= '0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      rdata_q  <= '0;
      dsize_q  <= SIZE_WORD;
      dbe_q    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q     <= bus.req_we_i;
        uns_q    <= bus.req_unsigned_i;
        size_q   <= bus.req_size_i;
        off_q    <= bus.req_addr_i[1:0];
        wdata_q  <= bus.req_wdata_i;
        daddr_q  <= {2'b00, bus.req_addr_i[31:2]};
        dsize_q  <= rmw_sub ? SIZE_WORD : bus.req_size_i;
        dbe_q    <= rmw_sub ? 4'hF : be;
        dwdata_q <= lane_data;
        err_q    <= misaligned;
        rdata_q  <= '0;
        cnt      <= '0;
      end
      if (state == RD) begin
        cnt <= cnt + 8'd1;
        if (rd_last) begin
          if (we_q) dwdata_q <= merged;
          else      rdata_q  <= load_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: default, RD_LAT=2 and RMW_EN=0 instances over zeroing word memories.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  vv = '0;
  logic        r_we = 1'b0, r_uns = 1'b0;
  logic [31:0] r_addr = '0, r_wdata = '0;
  logic [1:0]  r_size = 2'b10;

  lsu_mem_ctrl_if b0 ();
  lsu_mem_ctrl_if b1 ();
  lsu_mem_ctrl_if b2 ();

  lsu_mem_ctrl #(.RD_LAT(0), .RMW_EN(1'b1)) u0 (.clk_i(clk), .reset_ni(rst_n), .bus(b0));
  lsu_mem_ctrl #(.RD_LAT(2), .RMW_EN(1'b1)) u1 (.clk_i(clk), .reset_ni(rst_n), .bus(b1));
  lsu_mem_ctrl #(.RD_LAT(0), .RMW_EN(1'b0)) u2 (.clk_i(clk), .reset_ni(rst_n), .bus(b2));

  assign b0.req_valid_i = vv[0];
  assign b1.req_valid_i = vv[1];
  assign b2.req_valid_i = vv[2];
  assign {b0.req_we_i, b0.req_addr_i, b0.req_wdata_i, b0.req_size_i, b0.req_unsigned_i} = {r_we, r_addr, r_wdata, r_size, r_uns};
  assign {b1.req_we_i, b1.req_addr_i, b1.req_wdata_i, b1.req_size_i, b1.req_unsigned_i} = {r_we, r_addr, r_wdata, r_size, r_uns};
  assign {b2.req_we_i, b2.req_addr_i, b2.req_wdata_i, b2.req_size_i, b2.req_unsigned_i} = {r_we, r_addr, r_wdata, r_size, r_uns};

  // Word memories that zero bytes not selected by dbe on a write.
  logic [31:0] m0 [16];
  logic [31:0] m1 [16];
  logic [31:0] m2 [16];

  function automatic logic [31:0] wmask(input logic [31:0] d, input logic [3:0] be);
    wmask = {be[3] ? d[31:24] : 8'h00, be[2] ? d[23:16] : 8'h00,
             be[1] ? d[15:8]  : 8'h00, be[0] ? d[7:0]   : 8'h00};
  endfunction

  always @(posedge clk) if (b0.dwr_o) m0[b0.daddr_o[3:0]] <= wmask(b0.dwdata_o, b0.dbe_o);
  always @(posedge clk) if (b1.dwr_o) m1[b1.daddr_o[3:0]] <= wmask(b1.dwdata_o, b1.dbe_o);
  always @(posedge clk) if (b2.dwr_o) m2[b2.daddr_o[3:0]] <= wmask(b2.dwdata_o, b2.dbe_o);
  assign b0.drdata_i = m0[b0.daddr_o[3:0]];
  assign b1.drdata_i = m1[b1.daddr_o[3:0]];
  assign b2.drdata_i = m2[b2.daddr_o[3:0]];

  int sel = 0;
  logic        o_ready, o_rv, o_err, o_drd, o_dwr;
  logic [31:0] o_rdata, o_dwdata, o_daddr;
  logic [3:0]  o_dbe;
  logic [1:0]  o_dsize;

  always_comb begin
    {o_ready, o_rv, o_err, o_drd, o_dwr} = {b0.req_ready_o, b0.rsp_valid_o, b0.rsp_err_o, b0.drd_o, b0.dwr_o};
    {o_rdata, o_dwdata, o_daddr, o_dbe, o_dsize} = {b0.rsp_rdata_o, b0.dwdata_o, b0.daddr_o, b0.dbe_o, b0.dsize_o};
    if (sel == 1) begin
      {o_ready, o_rv, o_err, o_drd, o_dwr} = {b1.req_ready_o, b1.rsp_valid_o, b1.rsp_err_o, b1.drd_o, b1.dwr_o};
      {o_rdata, o_dwdata, o_daddr, o_dbe, o_dsize} = {b1.rsp_rdata_o, b1.dwdata_o, b1.daddr_o, b1.dbe_o, b1.dsize_o};
    end else if (sel == 2) begin
      {o_ready, o_rv, o_err, o_drd, o_dwr} = {b2.req_ready_o, b2.rsp_valid_o, b2.rsp_err_o, b2.drd_o, b2.dwr_o};
      {o_rdata, o_dwdata, o_daddr, o_dbe, o_dsize} = {b2.rsp_rdata_o, b2.dwdata_o, b2.daddr_o, b2.dbe_o, b2.dsize_o};
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue one request; count strobe cycles and the response cycle (1 = cycle after accept).
  task automatic req(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns,
                     output int lat, output int nrd, output int nwr, output logic [31:0] rdata,
                     output logic err, output logic [31:0] wd_seen, output logic [3:0] be_seen,
                     output int leak);
    int w;
    sel = d;
    @(negedge clk);
    {r_we, r_addr, r_wdata, r_size, r_uns} = {we, addr, wdata, size, uns};
    w = 0;
    while (!o_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    vv[d] = 1'b1;
    @(posedge clk);
    #1 vv = '0;
    lat = 0; nrd = 0; nwr = 0; leak = 0; rdata = '0; err = 1'b0; wd_seen = '0; be_seen = '0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (o_drd) nrd++;
      if (o_dwr) begin
        nwr++;
        wd_seen = o_dwdata;
        be_seen = o_dbe;
      end
      if (o_drd && o_dwr) leak++;
      if (o_rv) begin
        lat = k;
        rdata = o_rdata;
        err = o_err;
      end else if (o_rdata != '0 || o_err) leak++;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t tv [17];

  int lat, nrd, nwr, leak, bad_rst;
  logic [31:0] rdata, wd;
  logic err;
  logic [3:0] be;

  initial begin
    tv[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF, 4'hF};
    tv[1]  = '{1'b0, 32'h13, 32'h0,        SIZE_BYTE, 1'b0, 32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[2]  = '{1'b0, 32'h12, 32'h0,        SIZE_HALF, 1'b1, 32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[3]  = '{1'b0, 32'h12, 32'h0,        SIZE_HALF, 1'b0, 32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[4]  = '{1'b0, 32'h10, 32'h0,        SIZE_BYTE, 1'b1, 32'h000000EF, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[5]  = '{1'b0, 32'h10, 32'h0,        SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[6]  = '{1'b1, 32'h11, 32'hFFFFFF5A, SIZE_BYTE, 1'b0, 32'h0,        1'b0, 3, 1, 1, 32'hDEAD5AEF, 4'hF};
    tv[7]  = '{1'b0, 32'h10, 32'h0,        SIZE_WORD, 1'b0, 32'hDEAD5AEF, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[8]  = '{1'b1, 32'h12, 32'h00001234, SIZE_HALF, 1'b0, 32'h0,        1'b0, 3, 1, 1, 32'h12345AEF, 4'hF};
    tv[9]  = '{1'b0, 32'h10, 32'h0,        SIZE_WORD, 1'b0, 32'h12345AEF, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[10] = '{1'b0, 32'h12, 32'h0,        SIZE_WORD, 1'b0, 32'h0,        1'b1, 1, 0, 0, 32'h0, 4'h0};
    tv[11] = '{1'b0, 32'h10, 32'h0,        2'b11,     1'b0, 32'h0,        1'b1, 1, 0, 0, 32'h0, 4'h0};
    tv[12] = '{1'b1, 32'h11, 32'h00000001, SIZE_HALF, 1'b0, 32'h0,        1'b1, 1, 0, 0, 32'h0, 4'h0};
    tv[13] = '{1'b0, 32'h10, 32'h0,        SIZE_HALF, 1'b0, 32'h00005AEF, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[14] = '{1'b0, 32'h11, 32'h0,        SIZE_BYTE, 1'b0, 32'h0000005A, 1'b0, 2, 1, 0, 32'h0, 4'h0};
    tv[15] = '{1'b1, 32'h13, 32'h00000080, SIZE_BYTE, 1'b0, 32'h0,        1'b0, 3, 1, 1, 32'h80345AEF, 4'hF};
    tv[16] = '{1'b0, 32'h13, 32'h0,        SIZE_BYTE, 1'b0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0, 4'h0};

    #12;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_rv",    32'(o_rv),    32'd0);
    chk("rst_rdata", o_rdata,      32'h0);
    chk("rst_err",   32'(o_err),   32'd0);
    chk("rst_drd",   32'(o_drd),   32'd0);
    chk("rst_dwr",   32'(o_dwr),   32'd0);
    chk("rst_daddr", o_daddr,      32'h0);
    chk("rst_dwdata", o_dwdata,    32'h0);
    chk("rst_dbe",   32'(o_dbe),   32'h0);
    chk("rst_dsize", 32'(o_dsize), 32'(SIZE_WORD));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      req(0, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].size, tv[i].uns, lat, nrd, nwr, rdata, err, wd, be, leak);
      chk($sformatf("v%0d_lat", i),   32'(lat),  32'(tv[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), rdata,     tv[i].exp_rdata);
      chk($sformatf("v%0d_err", i),   32'(err),  32'(tv[i].exp_err));
      chk($sformatf("v%0d_nrd", i),   32'(nrd),  32'(tv[i].exp_nrd));
      chk($sformatf("v%0d_nwr", i),   32'(nwr),  32'(tv[i].exp_nwr));
      chk($sformatf("v%0d_leak", i),  32'(leak), 32'd0);
      chk($sformatf("v%0d_daddr", i), o_daddr,   {2'b00, tv[i].addr[31:2]});
      if (tv[i].exp_nwr != 0) begin
        chk($sformatf("v%0d_dwdata", i), wd,       tv[i].exp_wd);
        chk($sformatf("v%0d_dbe", i),    32'(be),  32'(tv[i].exp_be));
      end
    end

    // RD_LAT=2 instance
    req(1, 1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, lat, nrd, nwr, rdata, err, wd, be, leak);
    chk("l2_stw_lat", 32'(lat), 32'd2);
    req(1, 1'b0, 32'h12, 32'h0, SIZE_HALF, 1'b1, lat, nrd, nwr, rdata, err, wd, be, leak);
    chk("l2_ldh_lat", 32'(lat), 32'd4);
    chk("l2_ldh_nrd", 32'(nrd), 32'd3);
    chk("l2_ldh_rdata", rdata, 32'h0000DEAD);
    req(1, 1'b1, 32'h11, 32'h0000005A, SIZE_BYTE, 1'b0, lat, nrd, nwr, rdata, err, wd, be, leak);
    chk("l2_stb_lat", 32'(lat), 32'd5);
    chk("l2_stb_nrd", 32'(nrd), 32'd3);
    chk("l2_stb_dwdata", wd, 32'hDEAD5AEF);
    chk("l2_stb_leak", 32'(leak), 32'd0);

    // RMW_EN=0 instance: direct lane write, memory zeroes other bytes
    req(2, 1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, lat, nrd, nwr, rdata, err, wd, be, leak);
    chk("nr_stw_lat", 32'(lat), 32'd2);
    req(2, 1'b1, 32'h11, 32'h0000005A, SIZE_BYTE, 1'b0, lat, nrd, nwr, rdata, err, wd, be, leak);
    chk("nr_stb_lat", 32'(lat), 32'd2);
    chk("nr_stb_nrd", 32'(nrd), 32'd0);
    chk("nr_stb_dwdata", wd, 32'h5A5A5A5A);
    chk("nr_stb_dbe", 32'(be), 32'h2);
    chk("nr_stb_dsize", 32'(o_dsize), 32'(SIZE_BYTE));
    req(2, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, lat, nrd, nwr, rdata, err, wd, be, leak);
    chk("nr_ldw_rdata", rdata, 32'h00005A00);

    // Reset during the RD phase of a byte RMW store
    req(0, 1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, lat, nrd, nwr, rdata, err, wd, be, leak);
    sel = 0;
    @(negedge clk);
    {r_we, r_addr, r_wdata, r_size, r_uns} = {1'b1, 32'h11, 32'h0000005A, SIZE_BYTE, 1'b0};
    vv[0] = 1'b1;
    @(posedge clk);
    #1 vv = '0;
    chk("mr_drd_before", 32'(o_drd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_drd_async", 32'(o_drd), 32'd0);
    bad_rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_rv || o_dwr || o_drd) bad_rst++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_rv || o_dwr || o_drd) bad_rst++;
    end
    chk("mr_quiet", 32'(bad_rst), 32'd0);
    chk("mr_ready", 32'(o_ready), 32'd1);
    chk("mr_mem", m0[4], 32'hDEADBEEF);
    req(0, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, lat, nrd, nwr, rdata, err, wd, be, leak);
    chk("mr_ldw_lat", 32'(lat), 32'd2);
    chk("mr_ldw_rdata", rdata, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
